// File: rtl/ram_stream_reader.sv
// Read-side master for the simple dual-port RAM: walks a block of addresses and
// presents the returned words as a valid/ready stream through a 2-entry skid FIFO.
module ram_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [31:0]      count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      raddress,
    output logic             oe,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF >> (32 - DEPTH);

    state_e           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      issued_q, issued_d;
    logic [31:0]      accepted_q, accepted_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      raddr_q, raddr_d;
    logic [WIDTH-1:0] fifo0_q, fifo0_d;
    logic [WIDTH-1:0] fifo1_q, fifo1_d;
    logic [1:0]       occ_q, occ_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic             pop;
    logic             wr;
    logic             room;
    logic             issue;
    logic             last_beat;
    logic [31:0]      addr_now;

    // Handshake: a beat transfers on any rising edge where m_valid and m_ready
    // are both high; m_valid/m_data hold steady until that edge.
    always_comb begin
        pop       = valid_q & m_ready;
        wr        = inflight_q;
        addr_now  = (base_q + issued_q) & ADDR_MASK;
        // Words already buffered or in flight must still fit after this edge's pop.
        room      = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
        issue     = (state_q == ST_RUN) && (issued_q < count_q) && room;
        last_beat = pop && (accepted_q == count_q - 32'd1);
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d     = base;
                    count_d    = count;
                    issued_d   = 32'd0;
                    accepted_d = 32'd0;
                    state_d    = (count == 32'd0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    issued_d = issued_q + 32'd1;
                end
                if (pop) begin
                    accepted_d = accepted_q + 32'd1;
                end
                if (last_beat) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        inflight_d = issue;
        raddr_d    = issue ? addr_now : raddr_q;
        fifo0_d    = fifo0_q;
        fifo1_d    = fifo1_q;
        occ_d      = occ_q;
        case ({pop, wr})
            2'b01: begin
                if (occ_q == 2'd0) begin
                    fifo0_d = dout;
                end else begin
                    fifo1_d = dout;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b10: begin
                fifo0_d = fifo1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the head advances and the new word goes behind it.
                if (occ_q == 2'd1) begin
                    fifo0_d = dout;
                end else begin
                    fifo0_d = fifo1_q;
                    fifo1_d = dout;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
        valid_d = (occ_d != 2'd0);
        last_d  = valid_d && (accepted_d == count_d - 32'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= 32'd0;
            count_q    <= 32'd0;
            issued_q   <= 32'd0;
            accepted_q <= 32'd0;
            inflight_q <= 1'b0;
            raddr_q    <= 32'd0;
            fifo0_q    <= '0;
            fifo1_q    <= '0;
            occ_q      <= 2'd0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            raddr_q    <= raddr_d;
            fifo0_q    <= fifo0_d;
            fifo1_q    <= fifo1_d;
            occ_q      <= occ_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_FIN);
        oe       = issue;
        raddress = issue ? addr_now : raddr_q;
        m_data   = fifo0_q;
        m_valid  = valid_q;
        m_last   = last_q;
    end

`ifndef SYNTHESIS
    // A returning RAM word must always find a free FIFO slot.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(wr && !pop && (occ_q == 2'd2)));
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model, directed blocks, and a queue-based
// reference model checked every cycle against the stream and RAM address port.
module tb_ram_stream_reader;

    localparam int W = 32;
    localparam int D = 10;
    localparam int MEM_WORDS = 1 << D;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  base;
    logic [31:0]  count;
    logic         busy;
    logic         done;
    logic [31:0]  raddress;
    logic         oe;
    logic [W-1:0] dout;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    always #5 clk = ~clk;

    ram_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .raddress (raddress),
        .oe       (oe),
        .dout     (dout),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last)
    );

    // RAM read port: registered read, one cycle of latency.
    logic [W-1:0] mem [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (oe) dout <= mem[raddress[D-1:0]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model state
    logic [W-1:0] exp_q[$];
    logic         exp_last_q[$];
    logic [31:0]  exp_addr_q[$];
    int           outstanding = 0;
    bit           m_active = 0;
    int           exp_done_cyc = -1;
    int           cyc = 0;
    bit           prev_hold = 0;
    logic [W-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver
    bit   bp_mode = 0;
    bit   ready_level = 1;
    int   pidx = 0;
    logic rdy_pat [16] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1};

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                m_ready = rdy_pat[pidx % 16];
                pidx++;
            end else begin
                m_ready = ready_level;
            end
        end
    end

    // Compare process: one pass per cycle, on the falling edge.
    initial begin
        logic lst;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 0;
            end else begin
                chk("busy", busy, m_active);
                chk("done", done, m_active && (exp_done_cyc == cyc));
                if (m_active && (exp_done_cyc == cyc)) m_active = 0;
                if (prev_hold) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_data", m_data, prev_data);
                end
                if (oe === 1'b1) begin
                    if (exp_addr_q.size() == 0) chk("oe_spurious", oe, 0);
                    else begin
                        chk("raddress", raddress, exp_addr_q.pop_front());
                        outstanding++;
                    end
                end
                if (m_valid === 1'b1) begin
                    if (exp_q.size() == 0) chk("valid_spurious", m_valid, 0);
                    else begin
                        chk("m_data", m_data, exp_q[0]);
                        chk("m_last", m_last, exp_last_q[0]);
                        if (m_ready) begin
                            void'(exp_q.pop_front());
                            lst = exp_last_q.pop_front();
                            outstanding--;
                            if (lst) exp_done_cyc = cyc + 1;
                        end
                    end
                end else begin
                    chk("m_last_idle", m_last, 0);
                end
                chk("occ_bound", (outstanding > 2) ? 1 : 0, 0);
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
            end
        end
    end

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] c);
        logic [31:0] a;
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = b;
        count = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!m_active) begin
            m_active = 1;
            exp_done_cyc = (c == 0) ? cyc : -1;
            for (int i = 0; i < int'(c); i++) begin
                a = (b + i) % MEM_WORDS;
                exp_addr_q.push_back(a);
                exp_q.push_back(mem[a]);
                exp_last_q.push_back(i == int'(c) - 1);
            end
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
        chk("exp_drained", exp_q.size(), 0);
        chk("addr_drained", exp_addr_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_oe"}, oe, 0);
        chk({tag, "_raddress"}, raddress, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = i + 100;
        reset = 1'b1;
        start = 1'b0;
        base  = 32'd0;
        count = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        #2 reset = 1'b0;

        // Basic block: three beats back to back, first one after E2
        pulse_start(32'd4, 32'd3);
        @(negedge clk);
        chk("t1_e0_oe", oe, 1);
        chk("t1_e0_raddress", raddress, 4);
        chk("t1_e0_busy", busy, 1);
        @(negedge clk);
        chk("t1_e1_valid", m_valid, 0);
        @(negedge clk);
        chk("t1_e2_valid", m_valid, 1);
        chk("t1_e2_data", m_data, 104);
        @(negedge clk);
        chk("t1_e3_data", m_data, 105);
        @(negedge clk);
        chk("t1_e4_data", m_data, 106);
        chk("t1_e4_last", m_last, 1);
        @(negedge clk);
        chk("t1_e5_done", done, 1);
        @(negedge clk);
        chk("t1_after_done", done, 0);
        chk("t1_after_busy", busy, 0);

        // Empty block
        pulse_start(32'd7, 32'd0);
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_oe", oe, 0);
        chk("t2_valid", m_valid, 0);
        @(negedge clk);
        chk("t2_done_clear", done, 0);
        chk("t2_busy_clear", busy, 0);

        // Address wrap at the top of the RAM
        pulse_start(32'd1022, 32'd4);
        @(negedge clk);
        chk("t3_addr0", raddress, 1022);
        @(negedge clk);
        chk("t3_addr1", raddress, 1023);
        @(negedge clk);
        chk("t3_addr2", raddress, 0);
        chk("t3_data0", m_data, 1122);
        wait_done(20);

        // Backpressure, plus a start during RUN that must be ignored
        bp_mode = 1;
        pulse_start(32'd20, 32'd8);
        repeat (3) @(posedge clk);
        pulse_start(32'd500, 32'd2);
        wait_done(200);
        bp_mode = 0;

        // Reset while words are buffered, then a fresh block
        ready_level = 0;
        pulse_start(32'd300, 32'd8);
        repeat (5) @(posedge clk);
        #3;
        chk("t5_pre_valid", m_valid, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        exp_last_q.delete();
        exp_addr_q.delete();
        outstanding  = 0;
        m_active     = 0;
        exp_done_cyc = -1;
        @(negedge clk);
        #2;
        reset = 1'b0;
        ready_level = 1;
        pulse_start(32'd50, 32'd3);
        @(negedge clk);
        chk("t5_restart_addr", raddress, 50);
        wait_done(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
